// File: rtl/trap_seq_pkg.sv
// Shared types and constants for the trapezoid area sequencer.
package trap_seq_pkg;

    localparam int SMP_W  = 16;
    localparam int SURF_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        RUN,
        DRAIN,
        DONE
    } state_e;

    function automatic logic [SMP_W-1:0] clip_len(input logic [SMP_W-1:0] n,
                                                  input logic [SMP_W-1:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/trap_seq_acc.sv
// Frame accumulator: clear, add, and (with TRAP_SEQ_SAT_EN) saturation with a sticky overflow flag.
// Without TRAP_SEQ_SAT_EN the sum wraps modulo 2^ACC_W and ovf_o is tied low.
module trap_seq_acc #(
    parameter int ACC_W = 48,
    parameter int IN_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);

    logic [ACC_W-1:0] acc_q, acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

`ifdef TRAP_SEQ_SAT_EN
    // One guard bit above the wider operand catches any carry out of ACC_W.
    localparam int SUM_W = ((ACC_W > IN_W) ? ACC_W : IN_W) + 1;

    logic [SUM_W-1:0] sum;
    logic             ovf_q, ovf_d;

    assign sum = SUM_W'(acc_q) + SUM_W'(din);

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add) begin
            if (sum > SUM_W'({ACC_W{1'b1}})) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = acc_q + ACC_W'(din);
        end
    end

    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/trapezoid_area_sequencer.sv
// Streams height samples as consecutive pairs to the trapezoid unit and sums the returned surfaces per frame.
// Optional saturation is enabled by defining TRAP_SEQ_SAT_EN.
module trapezoid_area_sequencer
    import trap_seq_pkg::*;
#(
    parameter int ACC_W   = 48,
    parameter int MAX_SMP = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SMP_W-1:0]  cfg_num_samples,
    input  logic              s_valid,
    input  logic [SMP_W-1:0]  s_data,
    output logic              s_ready,
    output logic              calc_en,
    output logic [SMP_W-1:0]  calc_a,
    output logic [SMP_W-1:0]  calc_b,
    input  logic [SURF_W-1:0] calc_surf,
    input  logic              calc_valid,
    output logic              m_valid,
    output logic [ACC_W-1:0]  m_area,
    output logic              m_err_short,
    output logic              m_ovf,
    input  logic              m_ready,
    output logic              busy
);

    localparam logic [SMP_W-1:0] MAX_N = SMP_W'(MAX_SMP);

    state_e           state_q, state_d;
    logic [SMP_W-1:0] n_q, n_d;
    logic [SMP_W-1:0] cnt_q, cnt_d;
    logic [SMP_W-1:0] ret_q, ret_d;
    logic [SMP_W-1:0] prev_q, prev_d;
    logic             short_q, short_d;
    logic [SMP_W-1:0] n_clip;
    logic             acc_add;
    logic             acc_clr;

    assign n_clip  = clip_len(cfg_num_samples, MAX_N);
    assign acc_add = calc_valid && ((state_q == RUN) || (state_q == DRAIN));
    assign acc_clr = (state_q == DONE) && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            ret_q   <= '0;
            prev_q  <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            prev_q  <= prev_d;
            short_q <= short_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        ret_d   = acc_add ? ret_q + 16'd1 : ret_q;
        prev_d  = prev_q;
        short_d = short_q;
        s_ready = 1'b0;
        calc_en = 1'b0;
        calc_a  = '0;
        calc_b  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d   = n_clip;
                    cnt_d = '0;
                    ret_d = '0;
                    if (n_clip < 16'd2) begin
                        short_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = FIRST;
                    end
                end
            end
            FIRST: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    prev_d  = s_data;
                    cnt_d   = 16'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    calc_en = 1'b1;
                    calc_a  = prev_q;
                    calc_b  = s_data;
                    prev_d  = s_data;
                    cnt_d   = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == n_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave only once every one of the N-1 issued pairs has returned.
                if (calc_valid && (ret_q + 16'd1 == n_q - 16'd1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    short_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    trap_seq_acc #(
        .ACC_W (ACC_W),
        .IN_W  (SURF_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .add   (acc_add),
        .din   (calc_surf),
        .acc_o (m_area),
        .ovf_o (m_ovf)
    );

    assign m_valid     = (state_q == DONE);
    assign m_err_short = short_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_trapezoid_area_sequencer.sv
// Directed bench for trapezoid_area_sequencer with a 1-cycle trapezoid unit model.
module tb_trapezoid_area_sequencer;

    localparam int ACC_W   = 20;
    localparam int MAX_SMP = 8;

`ifdef TRAP_SEQ_SAT_EN
    localparam logic [ACC_W-1:0] SAT_AREA = 20'hFFFFF;
    localparam logic             SAT_OVF  = 1'b1;
`else
    localparam logic [ACC_W-1:0] SAT_AREA = 20'd1048544;
    localparam logic             SAT_OVF  = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      cfg;
    logic             s_valid;
    logic [15:0]      s_data;
    logic             s_ready;
    logic             calc_en;
    logic [15:0]      calc_a;
    logic [15:0]      calc_b;
    logic [31:0]      calc_surf;
    logic             calc_valid;
    logic             m_valid;
    logic [ACC_W-1:0] m_area;
    logic             m_err_short;
    logic             m_ovf;
    logic             m_ready;
    logic             busy;

    int          checks = 0;
    int          errors = 0;
    int          en_cnt = 0;
    int          rdy_cnt = 0;
    int          frame_cnt = 0;
    int          frames_before;
    logic [31:0] pairs[$];

    always #5 clk = ~clk;

    trapezoid_area_sequencer #(
        .ACC_W   (ACC_W),
        .MAX_SMP (MAX_SMP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_num_samples (cfg),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .calc_en         (calc_en),
        .calc_a          (calc_a),
        .calc_b          (calc_b),
        .calc_surf       (calc_surf),
        .calc_valid      (calc_valid),
        .m_valid         (m_valid),
        .m_area          (m_area),
        .m_err_short     (m_err_short),
        .m_ovf           (m_ovf),
        .m_ready         (m_ready),
        .busy            (busy)
    );

    // Trapezoid unit: surf = (a+b)<<3, one cycle after calc_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calc_valid <= 1'b0;
            calc_surf  <= '0;
        end else begin
            calc_valid <= calc_en;
            calc_surf  <= (32'(calc_a) + 32'(calc_b)) << 3;
        end
    end

    always @(negedge clk) begin
        #2;
        if (calc_en) begin
            en_cnt++;
            pairs.push_back({calc_a, calc_b});
        end
        if (s_ready) rdy_cnt++;
        if (m_valid && m_ready) frame_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end else begin
            $display("ok   %s got=%0d", tag, obs);
        end
    endtask

    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        cfg   = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        int guard;
        guard = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = v;
        #1;
        while (!s_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!s_ready) check("send_ready_timeout", s_ready, 1);
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic get_result(input string tag, input logic [ACC_W-1:0] area,
                              input logic short_e, input logic ovf_e,
                              input int hold, input logic start_too);
        int guard;
        guard = 0;
        #1;
        while (!m_valid && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_area"}, m_area, area);
        check({tag, "_short"}, m_err_short, short_e);
        check({tag, "_ovf"}, m_ovf, ovf_e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check({tag, "_hold_area"}, m_area, area);
            check({tag, "_hold_valid"}, m_valid, 1);
        end
        @(negedge clk);
        m_ready = 1'b1;
        start   = start_too;
        cfg     = 16'd3;
        @(negedge clk);
        m_ready = 1'b0;
        start   = 1'b0;
        #1;
        check({tag, "_idle"}, busy, 0);
        check({tag, "_mvalid_low"}, m_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_sready", s_ready, 0);
        check("rst_area", m_area, 0);
        @(negedge clk);
        rst = 1'b0;

        // N=3 back-to-back: pairs (10,20),(20,30) -> 240+400
        en_cnt = 0; pairs.delete();
        do_start(16'd3);
        send(16'd10); send(16'd20); send(16'd30);
        gap(1);
        get_result("n3", 20'd640, 1'b0, 1'b0, 0, 1'b0);
        check("n3_pairs", en_cnt, 2);
        check("n3_pair0", pairs[0], {16'd10, 16'd20});
        check("n3_pair1", pairs[1], {16'd20, 16'd30});

        // N=1: straight to DONE with the short flag
        en_cnt = 0; rdy_cnt = 0;
        do_start(16'd1);
        #1;
        check("n1_mvalid_next", m_valid, 1);
        get_result("n1", 20'd0, 1'b1, 1'b0, 0, 1'b0);
        check("n1_no_calc", en_cnt, 0);
        check("n1_no_sready", rdy_cnt, 0);

        en_cnt = 0;
        do_start(16'd0);
        get_result("n0", 20'd0, 1'b1, 1'b0, 0, 1'b0);
        check("n0_no_calc", en_cnt, 0);

        // N=4 with gaps, result held for 5 cycles: 24+40+56
        en_cnt = 0;
        do_start(16'd4);
        send(16'd1); gap(2);
        send(16'd2); gap(3);
        send(16'd3); gap(1);
        send(16'd4); gap(1);
        get_result("n4", 20'd120, 1'b0, 1'b0, 5, 1'b0);
        check("n4_pairs", en_cnt, 3);

        // Saturating / wrapping frame: each surf = 1048560
        do_start(16'd3);
        send(16'hFFFF); send(16'hFFFF); send(16'hFFFF);
        gap(1);
        get_result("sat", SAT_AREA, 1'b0, SAT_OVF, 0, 1'b0);

        // start during RUN ignored; start coincident with m_ready ignored
        frames_before = frame_cnt;
        do_start(16'd3);
        send(16'd10); send(16'd20);
        @(negedge clk);
        s_valid = 1'b0; start = 1'b1; cfg = 16'd2;
        @(negedge clk);
        start = 1'b0;
        send(16'd30);
        gap(1);
        get_result("ign", 20'd640, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        #1;
        check("ign_still_idle", busy, 0);
        check("ign_frames", frame_cnt - frames_before, 1);

        // N beyond MAX_SMP clipped: 8 ones -> 7 pairs of 16
        en_cnt = 0;
        do_start(16'd100);
        for (int i = 0; i < 8; i++) send(16'd1);
        @(negedge clk);
        s_data = 16'd99;
        #1;
        check("clip_sready_low", s_ready, 0);
        gap(1);
        get_result("clip", 20'd112, 1'b0, 1'b0, 0, 1'b0);
        check("clip_pairs", en_cnt, 7);

        // Reset mid-RUN, then a fresh N=2 frame
        do_start(16'd5);
        send(16'd10); send(16'd20); send(16'd30);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mvalid", m_valid, 0);
        check("mid_rst_sready", s_ready, 0);
        check("mid_rst_calc_en", calc_en, 0);
        check("mid_rst_area", m_area, 0);
        @(negedge clk);
        rst = 1'b0;
        do_start(16'd2);
        send(16'd5); send(16'd7);
        gap(1);
        get_result("post_rst", 20'd96, 1'b0, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
